// File: rtl/msrv32_bus_arbiter.sv
// ---------------------------------------------------------------------------
// msrv32_bus_arbiter
//
// Shares one AHB-Lite style master port between the instruction-fetch and
// data (load/store) ports of the core. A new address phase is issued at
// every arbitration point: whenever the bus is idle, or whenever the current
// data phase completes (hready_in high). Data requests normally win. A
// pending fetch is forced through after STARVE_LIMIT consecutive data
// grants, so that a stream of stores cannot lock out instruction fetch.
//
// Ports
//   ms_riscv32_mp_clk_in   clock, rising edge
//   ms_riscv32_mp_rst_in   asynchronous reset, active low
//   i_addr_in / i_req_in   fetch request
//   i_rdata_out            fetch read data (direct from hrdata_in)
//   i_hready_out           fetch complete, or fetch port idle
//   i_fault_out            fetch error response
//   d_addr_in, d_wdata_in, d_wr_in, d_mask_in, d_htrans_in
//                          data request (d_htrans_in[1] = request)
//   d_rdata_out            load data (direct from hrdata_in)
//   d_hready_out           data complete, or data port idle
//   d_hresp_out            data error response
//   haddr_out, hwrite_out, hstrb_out, htrans_out, hwdata_out
//                          shared bus address/data phase
//   hrdata_in, hready_in, hresp_in
//                          shared bus response
//   owner_out              data-phase owner: 00 none, 01 fetch, 10 data
// ---------------------------------------------------------------------------
module msrv32_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,

  input  logic [31:0] i_addr_in,
  input  logic        i_req_in,
  output logic [31:0] i_rdata_out,
  output logic        i_hready_out,
  output logic        i_fault_out,

  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic        d_wr_in,
  input  logic [3:0]  d_mask_in,
  input  logic [1:0]  d_htrans_in,
  output logic [31:0] d_rdata_out,
  output logic        d_hready_out,
  output logic        d_hresp_out,

  output logic [31:0] haddr_out,
  output logic        hwrite_out,
  output logic [3:0]  hstrb_out,
  output logic [1:0]  htrans_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in,

  output logic [1:0]  owner_out
);

  // State encoding doubles as the owner_out value.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_DATA = 2'b01,
    D_DATA = 2'b10
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     next_state;
  logic [3:0] starve_cnt;

  logic d_req;
  logic arb_point;
  logic starved;
  logic fetch_win;
  logic data_win;

  // Arbitration: an address phase may start when idle or when the current
  // data phase is completing in this cycle (back-to-back pipelining).
  always_comb begin
    d_req     = d_htrans_in[1];
    arb_point = (state == IDLE) || hready_in;
    starved   = (starve_cnt == LIMIT);
    fetch_win = arb_point && i_req_in && (!d_req || starved);
    data_win  = arb_point && d_req && !fetch_win;
  end

  // State register
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a stalled data phase simply holds.
  always_comb begin
    next_state = state;
    if (arb_point) begin
      if (fetch_win) begin
        next_state = I_DATA;
      end else if (data_win) begin
        next_state = D_DATA;
      end else begin
        next_state = IDLE;
      end
    end
  end

  // Output logic: address phase of the winner, responses routed to owner.
  always_comb begin
    haddr_out  = '0;
    hwrite_out = 1'b0;
    hstrb_out  = '0;
    htrans_out = 2'b00;
    if (fetch_win) begin
      haddr_out  = i_addr_in;
      htrans_out = 2'b10;
    end else if (data_win) begin
      haddr_out  = d_addr_in;
      htrans_out = 2'b10;
      hwrite_out = d_wr_in;
      hstrb_out  = d_wr_in ? d_mask_in : 4'b0000;
    end

    owner_out    = state;
    i_rdata_out  = hrdata_in;
    d_rdata_out  = hrdata_in;

    // A requester waiting for grant sees hready low; an idle port sees high.
    i_hready_out = ((state == I_DATA) && hready_in) || (!i_req_in && (state != I_DATA));
    d_hready_out = ((state == D_DATA) && hready_in) || (!d_req && (state != D_DATA));

    i_fault_out  = (state == I_DATA) && hresp_in;
    d_hresp_out  = (state == D_DATA) && hresp_in;
  end

  // Starvation counter: counts data grants made while a fetch is waiting.
  // The fetch always wins once the limit is reached, so the saturation
  // guard only matters for the limit value itself.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      starve_cnt <= '0;
    end else if (fetch_win || (arb_point && !i_req_in)) begin
      starve_cnt <= '0;
    end else if (data_win && i_req_in && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Write data for the data phase, captured with the address-phase grant
  // and held until the next data write is granted.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      hwdata_out <= '0;
    end else if (data_win && d_wr_in) begin
      hwdata_out <= d_wdata_in;
    end
  end

endmodule

// File: tb/tb_msrv32_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_msrv32_bus_arbiter
//
// Table-driven bench for msrv32_bus_arbiter (STARVE_LIMIT = 4). Each table
// row holds the inputs for one clock cycle and the hand-derived outputs for
// that cycle. Rows are driven just after a rising edge, their expectations
// queued, and popped/compared on the falling edge. Reset-mid-transfer and
// first-grant-after-reset are hand-written sequences at the end.
// ---------------------------------------------------------------------------
module tb_msrv32_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_addr_in;
  logic        i_req_in;
  logic [31:0] i_rdata_out;
  logic        i_hready_out;
  logic        i_fault_out;
  logic [31:0] d_addr_in;
  logic [31:0] d_wdata_in;
  logic        d_wr_in;
  logic [3:0]  d_mask_in;
  logic [1:0]  d_htrans_in;
  logic [31:0] d_rdata_out;
  logic        d_hready_out;
  logic        d_hresp_out;
  logic [31:0] haddr_out;
  logic        hwrite_out;
  logic [3:0]  hstrb_out;
  logic [1:0]  htrans_out;
  logic [31:0] hwdata_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;
  logic [1:0]  owner_out;

  msrv32_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .i_addr_in            (i_addr_in),
    .i_req_in             (i_req_in),
    .i_rdata_out          (i_rdata_out),
    .i_hready_out         (i_hready_out),
    .i_fault_out          (i_fault_out),
    .d_addr_in            (d_addr_in),
    .d_wdata_in           (d_wdata_in),
    .d_wr_in              (d_wr_in),
    .d_mask_in            (d_mask_in),
    .d_htrans_in          (d_htrans_in),
    .d_rdata_out          (d_rdata_out),
    .d_hready_out         (d_hready_out),
    .d_hresp_out          (d_hresp_out),
    .haddr_out            (haddr_out),
    .hwrite_out           (hwrite_out),
    .hstrb_out            (hstrb_out),
    .htrans_out           (htrans_out),
    .hwdata_out           (hwdata_out),
    .hrdata_in            (hrdata_in),
    .hready_in            (hready_in),
    .hresp_in             (hresp_in),
    .owner_out            (owner_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic [1:0]  dtr;
    logic [31:0] daddr;
    logic        dwr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        hready;
    logic        hresp;
    logic [1:0]  e_owner;
    logic [1:0]  e_htrans;
    logic [31:0] e_haddr;
    logic        e_hwrite;
    logic [3:0]  e_hstrb;
    logic        e_ihr;
    logic        e_dhr;
    logic        e_ifault;
    logic        e_dresp;
    logic [31:0] e_hwdata;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    vec_t        v;
  } sb_t;

  localparam int NV = 24;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  vec_t tbl [NV];
  sb_t  sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [31:0] rd);
    i_req_in    = v.ireq;
    i_addr_in   = v.iaddr;
    d_htrans_in = v.dtr;
    d_addr_in   = v.daddr;
    d_wr_in     = v.dwr;
    d_wdata_in  = v.wdata;
    d_mask_in   = v.mask;
    hready_in   = v.hready;
    hresp_in    = v.hresp;
    hrdata_in   = rd;
  endtask

  task automatic step(input int idx);
    sb_t s;
    s.idx   = idx;
    s.rdata = $urandom;
    s.v     = tbl[idx];
    drive(s.v, s.rdata);
    sb.push_back(s);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      sb_t e;
      e = sb.pop_front();
      chk($sformatf("v%0d.owner", e.idx),  32'(owner_out),    32'(e.v.e_owner));
      chk($sformatf("v%0d.htrans", e.idx), 32'(htrans_out),   32'(e.v.e_htrans));
      chk($sformatf("v%0d.haddr", e.idx),  haddr_out,         e.v.e_haddr);
      chk($sformatf("v%0d.hwrite", e.idx), 32'(hwrite_out),   32'(e.v.e_hwrite));
      chk($sformatf("v%0d.hstrb", e.idx),  32'(hstrb_out),    32'(e.v.e_hstrb));
      chk($sformatf("v%0d.i_hready", e.idx), 32'(i_hready_out), 32'(e.v.e_ihr));
      chk($sformatf("v%0d.d_hready", e.idx), 32'(d_hready_out), 32'(e.v.e_dhr));
      chk($sformatf("v%0d.i_fault", e.idx),  32'(i_fault_out),  32'(e.v.e_ifault));
      chk($sformatf("v%0d.d_hresp", e.idx),  32'(d_hresp_out),  32'(e.v.e_dresp));
      chk($sformatf("v%0d.hwdata", e.idx), hwdata_out,        e.v.e_hwdata);
      chk($sformatf("v%0d.i_rdata", e.idx), i_rdata_out,      e.rdata);
      chk($sformatf("v%0d.d_rdata", e.idx), d_rdata_out,      e.rdata);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            ireq iaddr        dtr    daddr        dwr   wdata         mask   hrdy  hresp  | owner  htrans haddr        hwr   hstrb  ihr   dhr   ifl   drsp  hwdata
    // single fetch
    tbl[0]  = '{1'b1, 32'h100,  2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00, 2'b10, 32'h100,  1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b01, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    // collision: data first (with one wait state), fetch at data completion
    tbl[3]  = '{1'b1, 32'h200,  2'b10, 32'h8000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00, 2'b10, 32'h8000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 32'h200,  2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b10, 2'b00, 32'h0,    1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'h200,  2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b10, 2'b10, 32'h200,  1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b01, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    // data write with two wait states
    tbl[7]  = '{1'b0, 32'h0,    2'b10, 32'h10,   1'b1, DB,    4'h3, 1'b1, 1'b0, 2'b00, 2'b10, 32'h10,   1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b10, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, DB};
    tbl[9]  = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b10, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, DB};
    tbl[10] = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b10, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, DB};
    tbl[11] = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, DB};
    // fetch error, then stray hresp while idle, then data error
    tbl[12] = '{1'b1, 32'h300,  2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00, 2'b10, 32'h300,  1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, DB};
    tbl[13] = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 2'b01, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, DB};
    tbl[14] = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 2'b00, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, DB};
    tbl[15] = '{1'b0, 32'h0,    2'b10, 32'h44,   1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b00, 2'b10, 32'h44,   1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, DB};
    tbl[16] = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 2'b10, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, DB};
    // starvation: 4 data grants, 1 fetch grant, data resumes (reads: no strobes)
    tbl[17] = '{1'b1, 32'h400,  2'b10, 32'h1000, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 2'b00, 2'b10, 32'h1000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, DB};
    tbl[18] = '{1'b1, 32'h400,  2'b10, 32'h1004, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 2'b10, 2'b10, 32'h1004, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, DB};
    tbl[19] = '{1'b1, 32'h400,  2'b10, 32'h1008, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 2'b10, 2'b10, 32'h1008, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, DB};
    tbl[20] = '{1'b1, 32'h400,  2'b10, 32'h100C, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 2'b10, 2'b10, 32'h100C, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, DB};
    tbl[21] = '{1'b1, 32'h400,  2'b10, 32'h1010, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 2'b10, 2'b10, 32'h400,  1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, DB};
    tbl[22] = '{1'b0, 32'h0,    2'b10, 32'h1010, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 2'b01, 2'b10, 32'h1010, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, DB};
    tbl[23] = '{1'b0, 32'h0,    2'b00, 32'h0,    1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 2'b10, 2'b00, 32'h0,    1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, DB};

    // reset state
    rst_n = 1'b0;
    drive(tbl[2], 32'h0);
    #3;
    chk("rst.owner",  32'(owner_out),  32'd0);
    chk("rst.htrans", 32'(htrans_out), 32'd0);
    chk("rst.hwdata", hwdata_out,      32'd0);
    chk("rst.starve", 32'(dut.starve_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      step(i);
    end

    // reset in the middle of a data phase, with a fetch counted as starved
    i_req_in = 1'b1; i_addr_in = 32'h500;
    d_htrans_in = 2'b10; d_addr_in = 32'h20; d_wr_in = 1'b1;
    d_wdata_in = 32'h1234_5678; d_mask_in = 4'hF; hready_in = 1'b1; hresp_in = 1'b0;
    @(posedge clk);
    #1;
    i_req_in = 1'b0; d_htrans_in = 2'b00; d_wr_in = 1'b0; hready_in = 1'b0;
    chk("mid.owner",  32'(owner_out), 32'd2);
    chk("mid.starve", 32'(dut.starve_cnt), 32'd1);
    chk("mid.hwdata", hwdata_out, 32'h1234_5678);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.owner",  32'(owner_out),  32'd0);
    chk("arst.htrans", 32'(htrans_out), 32'd0);
    chk("arst.haddr",  haddr_out,       32'd0);
    chk("arst.hwdata", hwdata_out,      32'd0);
    chk("arst.starve", 32'(dut.starve_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset release grants a fetch
    i_req_in = 1'b1; i_addr_in = 32'h600; hready_in = 1'b1;
    #1;
    chk("post.htrans", 32'(htrans_out), 32'd2);
    chk("post.haddr",  haddr_out,       32'h600);
    @(posedge clk);
    #1;
    i_req_in = 1'b0;
    #1;
    chk("post.owner",    32'(owner_out),    32'd1);
    chk("post.i_hready", 32'(i_hready_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/msrv32_bus_arbiter.md
MSRV32_BUS_ARBITER -- requirements
Module: msrv32_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch waits (range 1-15).
REQ-002 SHALL have port ms_riscv32_mp_clk_in, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_in, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port i_addr_in, input, 32: fetch address, held while i_req_in high and i_hready_out low.
REQ-005 SHALL have port i_req_in, input, 1: fetch request.
REQ-006 SHALL have port i_rdata_out, output, 32: fetch read data, equal to hrdata_in.
REQ-007 SHALL have port i_hready_out, output, 1: fetch transfer complete / port idle.
REQ-008 SHALL have port i_fault_out, output, 1: fetch error response.
REQ-009 SHALL have port d_addr_in, input, 32: data address, held until d_hready_out.
REQ-010 SHALL have port d_wdata_in, input, 32: store data, valid with the request.
REQ-011 SHALL have port d_wr_in, input, 1: 1 = write.
REQ-012 SHALL have port d_mask_in, input, 4: byte write mask.
REQ-013 SHALL have port d_htrans_in, input, 2: data request when bit 1 is set (NONSEQ/SEQ).
REQ-014 SHALL have port d_rdata_out, output, 32: load data, equal to hrdata_in.
REQ-015 SHALL have ports d_hready_out and d_hresp_out, outputs, 1 each: data completion and error.
REQ-016 SHALL have port haddr_out, output, 32: shared bus address.
REQ-017 SHALL have ports hwrite_out, output, 1, and hstrb_out, output, 4: bus write and write strobes.
REQ-018 SHALL have ports htrans_out, output, 2, and hwdata_out, output, 32: bus transfer type and write data.
REQ-019 SHALL have ports hrdata_in, input, 32; hready_in, input, 1; hresp_in, input, 1: bus response.
REQ-020 SHALL have port owner_out, output, 2: data-phase owner, 00 none / 01 fetch / 10 data.

Function
REQ-021 SHALL implement states IDLE, I_DATA and D_DATA, encoded on owner_out.
REQ-022 SHALL treat an arbitration point as state IDLE, or state I_DATA/D_DATA with hready_in=1.
REQ-023 SHALL select the winner at an arbitration point: data wins over fetch unless starve_cnt==STARVE_LIMIT and i_req_in=1, in which case fetch wins.
REQ-024 SHALL drive the address phase combinationally at an arbitration point with a winner: haddr_out = winner address, htrans_out = 2'b10, hwrite_out = d_wr_in for data, 0 for fetch, hstrb_out = d_mask_in for data writes, else 0.
REQ-025 SHALL drive htrans_out=00 and haddr_out, hwrite_out, hstrb_out = 0 when there is no arbitration point or no winner.
REQ-026 SHALL set the next state on a clock edge at an arbitration point: I_DATA if fetch wins, D_DATA if data wins, IDLE if neither requests.
REQ-027 SHALL hold state, with no new address phase, while I_DATA/D_DATA has hready_in=0.
REQ-028 SHALL register hwdata_out <= d_wdata_in on a clock edge where a data write wins; hwdata_out SHALL then hold until the next such grant.
REQ-029 SHALL set i_hready_out = (state==I_DATA and hready_in) or (i_req_in==0 and state!=I_DATA).
REQ-030 SHALL set d_hready_out = (state==D_DATA and hready_in) or (d_htrans_in[1]==0 and state!=D_DATA).
REQ-031 SHALL keep a requester that is waiting for grant at hready_out=0.
REQ-032 SHALL pass hresp_in only to the current owner: i_fault_out in I_DATA, d_hresp_out in D_DATA; the other port SHALL see 0.
REQ-033 SHALL manage starve_cnt (4 bits) as follows:
- increment, saturating at STARVE_LIMIT, on each data grant while i_req_in=1;
- clear on a fetch grant or when i_req_in=0 at an arbitration point.
REQ-034 SHALL issue back-to-back transfers with no idle cycle: a new address phase in the same cycle the previous data phase completes.
REQ-035 SHALL not restart a requester's transfer on an error response; the transfer completes with hresp flagged.

Reset
REQ-036 SHALL on assertion of ms_riscv32_mp_rst_in, immediately and regardless of clock:
- set state = IDLE, starve_cnt = 0, hwdata_out = 0, owner_out = 00;
- discard any in-flight data phase, with no completion signalled.
REQ-037 SHALL be able to grant a transfer on the first rising edge after reset deasserts.

Verification
REQ-038 SHALL verify single fetch: i_req_in=1, i_addr_in=0x100, hready_in=1 -> cycle 0 haddr_out=0x100, htrans_out=10; cycle 1 owner_out=01, i_hready_out=1, i_rdata_out=hrdata_in.
REQ-039 SHALL verify collision: fetch 0x200 and data read 0x8000 in the same cycle -> data granted first; fetch granted at the completion cycle of the data phase; i_hready_out=0 until then.
REQ-040 SHALL verify starvation with STARVE_LIMIT=4: continuous data requests plus a pending fetch -> 4 data grants, then 1 fetch grant, then data resumes.
REQ-041 SHALL verify wait state plus write: data write 0x10, wdata 0xDEADBEEF, mask 0011, hready_in low for 2 cycles -> hwdata_out=0xDEADBEEF held for 3 cycles, htrans_out=00 while stalled, d_hready_out pulses once.
REQ-042 SHALL verify error: hresp_in=1 during a fetch data phase -> i_fault_out=1 for 1 cycle, d_hresp_out=0.
REQ-043 SHALL verify reset mid-transfer: rst low during D_DATA -> owner_out=00, htrans_out=00, starve_cnt=0 with no clock edge required.
